// File: rtl/pid_mc.sv
// pid_mc: time-multiplexed multi-channel PID controller.
// Each start_i pulse (while idle) sweeps channels 0..CHN_NUM-1. Per channel the
// FSM walks LOAD -> ACC -> SUM -> OUT. On the OUT cycle it emits one saturated
// control value on the u_valid_o/u_chn_o/u_data_o triple. Integrator and
// previous-error history persist per channel between sweeps.
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start_i              one-cycle pulse, begins a sweep when idle
//   clr_i                clears all integrators/previous errors when idle
//   sp_i, fb_i           packed signed setpoint/feedback, channel c at [c*DW +: DW]
//   kp_i, ki_i, kd_i     unsigned fixed-point gains (FRAC fraction bits)
//   busy_o               high while a sweep is in progress
//   u_valid_o            one-cycle strobe qualifying u_chn_o/u_data_o
//   u_chn_o, u_data_o    channel index and saturated control value (held)
module pid_mc #(
    parameter int unsigned CHN_NUM = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned GW      = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned UW      = 16,
    parameter int unsigned ILIM    = 30000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       clr_i,
    input  logic [CHN_NUM*DW-1:0]      sp_i,
    input  logic [CHN_NUM*DW-1:0]      fb_i,
    input  logic [GW-1:0]              kp_i,
    input  logic [GW-1:0]              ki_i,
    input  logic [GW-1:0]              kd_i,
    output logic                       busy_o,
    output logic                       u_valid_o,
    output logic [$clog2(CHN_NUM)-1:0] u_chn_o,
    output logic [UW-1:0]              u_data_o
);

    localparam int unsigned CW  = $clog2(CHN_NUM);
    localparam int unsigned EW  = DW + 1;       // error width, sp-fb never overflows
    localparam int unsigned DDW = DW + 2;       // derivative width
    localparam int unsigned IW  = DW + 4;       // integrator width, holds +-ILIM
    localparam int unsigned SW  = GW + IW + 4;  // PID accumulator, no intermediate wrap

    localparam logic signed [IW:0]   ILIM_POS = (IW+1)'(ILIM);
    localparam logic signed [IW:0]   ILIM_NEG = -ILIM_POS;
    localparam logic signed [SW-1:0] U_MAX    = $signed({{(SW-UW+1){1'b0}}, {(UW-1){1'b1}}});
    localparam logic signed [SW-1:0] U_MIN    = $signed({{(SW-UW+1){1'b1}}, {(UW-1){1'b0}}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACC,
        S_SUM,
        S_OUT
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           chn_q, chn_d;
    logic [GW-1:0]           kp_q, kp_d;
    logic [GW-1:0]           ki_q, ki_d;
    logic [GW-1:0]           kd_q, kd_d;
    logic signed [EW-1:0]    e_q, e_d;
    logic signed [IW-1:0]    i_new_q, i_new_d;
    logic signed [DDW-1:0]   d_q, d_d;
    logic signed [IW-1:0]    integ_q [CHN_NUM];
    logic signed [IW-1:0]    integ_d [CHN_NUM];
    logic signed [EW-1:0]    e_prev_q [CHN_NUM];
    logic signed [EW-1:0]    e_prev_d [CHN_NUM];
    logic                    busy_q, busy_d;
    logic                    u_valid_q, u_valid_d;
    logic [CW-1:0]           u_chn_q, u_chn_d;
    logic [UW-1:0]           u_data_q, u_data_d;

    // Unpacked views of the packed per-channel inputs
    logic signed [DW-1:0]    sp_arr [CHN_NUM];
    logic signed [DW-1:0]    fb_arr [CHN_NUM];

    always_comb begin : unpack
        for (int unsigned c = 0; c < CHN_NUM; c++) begin
            sp_arr[c] = sp_i[c*DW +: DW];
            fb_arr[c] = fb_i[c*DW +: DW];
        end
    end

    // Datapath for the currently selected channel
    logic signed [EW-1:0]    e_new;
    logic signed [IW:0]      i_sum;
    logic signed [IW-1:0]    i_clamp;
    logic signed [DDW-1:0]   d_new;
    logic signed [SW-1:0]    p_term;
    logic signed [SW-1:0]    i_term;
    logic signed [SW-1:0]    d_term;
    logic signed [SW-1:0]    pid_sum;
    logic signed [SW-1:0]    pid_shift;
    logic [UW-1:0]           u_sat;

    always_comb begin : datapath
        e_new = EW'(sp_arr[chn_q]) - EW'(fb_arr[chn_q]);

        i_sum = (IW+1)'(integ_q[chn_q]) + (IW+1)'(e_q);
        if (i_sum > ILIM_POS) begin
            i_clamp = IW'(ILIM_POS);
        end else if (i_sum < ILIM_NEG) begin
            i_clamp = IW'(ILIM_NEG);
        end else begin
            i_clamp = IW'(i_sum);
        end

        d_new = DDW'(e_q) - DDW'(e_prev_q[chn_q]);

        // Gains are zero-extended into the signed accumulator domain
        p_term  = $signed(SW'({1'b0, kp_q})) * SW'(e_q);
        i_term  = $signed(SW'({1'b0, ki_q})) * SW'(i_new_q);
        d_term  = $signed(SW'({1'b0, kd_q})) * SW'(d_q);
        pid_sum = p_term + i_term + d_term;

        // Arithmetic shift = floor division by 2^FRAC
        pid_shift = pid_sum >>> FRAC;

        if (pid_shift > U_MAX) begin
            u_sat = UW'(U_MAX);
        end else if (pid_shift < U_MIN) begin
            u_sat = UW'(U_MIN);
        end else begin
            u_sat = UW'(pid_shift);
        end
    end

    // Next-state and register-input logic
    always_comb begin : next_state
        state_d   = state_q;
        chn_d     = chn_q;
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        e_d       = e_q;
        i_new_d   = i_new_q;
        d_d       = d_q;
        integ_d   = integ_q;
        e_prev_d  = e_prev_q;
        busy_d    = busy_q;
        u_valid_d = 1'b0;
        u_chn_d   = u_chn_q;
        u_data_d  = u_data_q;

        case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    // Clear wins over a simultaneous start
                    for (int unsigned c = 0; c < CHN_NUM; c++) begin
                        integ_d[c]  = '0;
                        e_prev_d[c] = '0;
                    end
                end else if (start_i) begin
                    kp_d    = kp_i;
                    ki_d    = ki_i;
                    kd_d    = kd_i;
                    chn_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                e_d     = e_new;
                state_d = S_ACC;
            end
            S_ACC: begin
                integ_d[chn_q]  = i_clamp;
                i_new_d         = i_clamp;
                d_d             = d_new;
                e_prev_d[chn_q] = e_q;
                state_d         = S_SUM;
            end
            S_SUM: begin
                u_valid_d = 1'b1;
                u_chn_d   = chn_q;
                u_data_d  = u_sat;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (chn_q == CW'(CHN_NUM - 1)) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    chn_d   = chn_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chn_q     <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            e_q       <= '0;
            i_new_q   <= '0;
            d_q       <= '0;
            for (int unsigned c = 0; c < CHN_NUM; c++) begin
                integ_q[c]  <= '0;
                e_prev_q[c] <= '0;
            end
            busy_q    <= 1'b0;
            u_valid_q <= 1'b0;
            u_chn_q   <= '0;
            u_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            chn_q     <= chn_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            kd_q      <= kd_d;
            e_q       <= e_d;
            i_new_q   <= i_new_d;
            d_q       <= d_d;
            integ_q   <= integ_d;
            e_prev_q  <= e_prev_d;
            busy_q    <= busy_d;
            u_valid_q <= u_valid_d;
            u_chn_q   <= u_chn_d;
            u_data_q  <= u_data_d;
        end
    end

    assign busy_o    = busy_q;
    assign u_valid_o = u_valid_q;
    assign u_chn_o   = u_chn_q;
    assign u_data_o  = u_data_q;

endmodule

// File: tb/tb_pid_mc.sv
// tb_pid_mc: self-checking bench for pid_mc. A sweep-level model predicts every
// channel's output when a start is accepted; a compare process checks busy,
// strobe, channel and held data on every falling edge. Directed scenarios add
// hand-computed literal expectations.
module tb_pid_mc;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int GW   = 16;
    localparam int FRAC = 8;
    localparam int UW   = 16;
    localparam int ILIM = 30000;
    localparam int CW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [N*DW-1:0]   sp_i = '0;
    logic [N*DW-1:0]   fb_i = '0;
    logic [GW-1:0]     kp_i = '0;
    logic [GW-1:0]     ki_i = '0;
    logic [GW-1:0]     kd_i = '0;
    logic              busy_o;
    logic              u_valid_o;
    logic [CW-1:0]     u_chn_o;
    logic [UW-1:0]     u_data_o;

    pid_mc #(
        .CHN_NUM (N),
        .DW      (DW),
        .GW      (GW),
        .FRAC    (FRAC),
        .UW      (UW),
        .ILIM    (ILIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .clr_i     (clr_i),
        .sp_i      (sp_i),
        .fb_i      (fb_i),
        .kp_i      (kp_i),
        .ki_i      (ki_i),
        .kd_i      (kd_i),
        .busy_o    (busy_o),
        .u_valid_o (u_valid_o),
        .u_chn_o   (u_chn_o),
        .u_data_o  (u_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_int [N];
    longint m_eprev [N];
    longint exp_u [N];
    int     t = -1;          // edges since the accepting edge, -1 when idle

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            m_int[c]   = 0;
            m_eprev[c] = 0;
        end
    endtask

    // Whole sweep computed at once from the rules: error, clamped integral, derivative
    task automatic model_sweep();
        logic signed [DW-1:0] sv;
        logic signed [DW-1:0] fv;
        longint e, i, d, s, u;
        for (int c = 0; c < N; c++) begin
            sv = sp_i[c*DW +: DW];
            fv = fb_i[c*DW +: DW];
            e  = longint'(sv) - longint'(fv);
            i  = m_int[c] + e;
            if (i > ILIM) i = ILIM;
            if (i < -ILIM) i = -ILIM;
            d  = e - m_eprev[c];
            m_int[c]   = i;
            m_eprev[c] = e;
            s = longint'(kp_i) * e + longint'(ki_i) * i + longint'(kd_i) * d;
            u = floor_div(s, longint'(1) << FRAC);
            if (u > 32767) u = 32767;
            if (u < -32768) u = -32768;
            exp_u[c] = u;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            t = -1;
            model_clear();
        end else if (t < 0) begin
            if (clr_i) begin
                model_clear();
            end else if (start_i) begin
                model_sweep();
                t = 0;
            end
        end else begin
            t = (t == 4*N - 1) ? -1 : t + 1;
        end
    end

    // ---------------- compare process ----------------
    longint last_chn = 0;
    longint last_data = 0;
    longint obs_u [N];
    int     dut_strobes = 0;
    longint first_chn = -1;

    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            chk("rst_busy", longint'(busy_o), 0);
            chk("rst_valid", longint'(u_valid_o), 0);
            chk("rst_chn", longint'(u_chn_o), 0);
            chk("rst_data", longint'($signed(u_data_o)), 0);
            last_chn  = 0;
            last_data = 0;
        end else begin
            ev = (t >= 0) && ((t % 4) == 3);
            chk("busy", longint'(busy_o), (t >= 0) ? 1 : 0);
            chk("valid", longint'(u_valid_o), ev ? 1 : 0);
            if (ev) begin
                last_chn  = t / 4;
                last_data = exp_u[t / 4];
            end
            chk("chn", longint'(u_chn_o), last_chn);
            chk("data", longint'($signed(u_data_o)), last_data);
            if (u_valid_o) begin
                if (dut_strobes == 0) first_chn = longint'(u_chn_o);
                obs_u[u_chn_o] = longint'($signed(u_data_o));
                dut_strobes++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ch(input int c, input longint sp, input longint fb);
        sp_i[c*DW +: DW] = DW'(sp);
        fb_i[c*DW +: DW] = DW'(fb);
    endtask

    task automatic zero_inputs();
        sp_i = '0;
        fb_i = '0;
    endtask

    task automatic set_gains(input int kp, input int ki, input int kd);
        kp_i = GW'(kp);
        ki_i = GW'(ki);
        kd_i = GW'(kd);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_i = 1'b1;
        @(posedge clk); #1 clr_i = 1'b0;
    endtask

    // Start pulse, then wait until the FSM is idle again
    task automatic sweep();
        dut_strobes = 0;
        first_chn   = -1;
        for (int c = 0; c < N; c++) obs_u[c] = 99999;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (4*N) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_lit", longint'(busy_o), 0);
        chk("reset_valid_lit", longint'(u_valid_o), 0);
        chk("reset_data_lit", longint'($signed(u_data_o)), 0);
        rst = 1'b0;

        // P-only, channel independence
        set_gains(256, 0, 0);
        set_ch(0, 100, 40); set_ch(1, 0, 0); set_ch(2, -50, 50); set_ch(3, 7, 7);
        sweep();
        chk("p_ch0", obs_u[0], 60);
        chk("p_ch1", obs_u[1], 0);
        chk("p_ch2", obs_u[2], -100);
        chk("p_ch3", obs_u[3], 0);
        chk("p_strobes", dut_strobes, 4);
        chk("p_busy_after", longint'(busy_o), 0);

        // Integral with clamp, then clear
        pulse_clr();
        zero_inputs();
        set_gains(0, 256, 0);
        set_ch(0, 20000, 0);
        sweep();
        chk("i_sweep1", obs_u[0], 20000);
        chk("i_other", obs_u[1], 0);
        sweep();
        chk("i_sweep2", obs_u[0], 30000);
        sweep();
        chk("i_sweep3", obs_u[0], 30000);
        pulse_clr();
        sweep();
        chk("i_after_clr", obs_u[0], 20000);

        // Derivative
        pulse_clr();
        zero_inputs();
        set_gains(0, 0, 256);
        set_ch(1, 50, 0);
        sweep();
        chk("d_sweep1", obs_u[1], 50);
        sweep();
        chk("d_sweep2", obs_u[1], 0);
        set_ch(1, 20, 0);
        sweep();
        chk("d_sweep3", obs_u[1], -30);

        // Saturation and floor
        pulse_clr();
        zero_inputs();
        set_gains(65535, 0, 0);
        set_ch(0, 1000, 0);
        set_ch(1, 0, 1000);
        sweep();
        chk("sat_pos", obs_u[0], 32767);
        chk("sat_neg", obs_u[1], -32768);
        zero_inputs();
        set_gains(128, 0, 0);
        set_ch(2, -3, 0);
        sweep();
        chk("floor_neg", obs_u[2], -2);

        // start mid-sweep is ignored
        pulse_clr();
        zero_inputs();
        set_gains(256, 0, 0);
        set_ch(0, 10, 0); set_ch(3, 0, 5);
        dut_strobes = 0;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (4*N - 5) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_start_strobes", dut_strobes, 4);
        chk("mid_start_ch3", obs_u[3], -5);

        // start together with clr: clears, no sweep
        pulse_clr();
        zero_inputs();
        set_gains(0, 256, 0);
        set_ch(0, 100, 0);
        sweep();
        chk("sc_pre", obs_u[0], 100);
        dut_strobes = 0;
        @(posedge clk); #1 start_i = 1'b1; clr_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0; clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sc_busy", longint'(busy_o), 0);
        chk("sc_no_strobe", dut_strobes, 0);
        sweep();
        chk("sc_cleared", obs_u[0], 100);

        // Reset mid-sweep
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_data", longint'($signed(u_data_o)), 200);
        chk("pre_rst_busy", longint'(busy_o), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", longint'(u_valid_o), 0);
        chk("mid_rst_busy", longint'(busy_o), 0);
        chk("mid_rst_data", longint'($signed(u_data_o)), 0);
        @(posedge clk); #1 rst = 1'b0;
        sweep();
        chk("post_rst_first_chn", first_chn, 0);
        chk("post_rst_ch0", obs_u[0], 100);
        chk("post_rst_strobes", dut_strobes, 4);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
